// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Select-line sequencer and capture stage wrapped around a 4:1 mux.
//   On start it steps {s1,s0} through channels 0..3. Each channel settles for
//   DWELL cycles and is then sampled for one cycle. The four samples are packed
//   into one word, which is offered downstream on a valid/ready handshake.
//
// Parameters
//   DWELL   settle cycles per channel before sampling (1 .. 2**CNT_W-1)
//   CNT_W   width of the dwell counter
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-high reset
//   start    in   begin one scan (honoured only while idle)
//   s1, s0   out  registered mux selects, always equal to the channel index
//   mux_out  in   output of the scanned mux
//   data     out  packed samples, bit0 = channel 0 ... bit3 = channel 3
//   valid    out  data available, held until ready is seen
//   ready    in   downstream accepts data
//   busy     out  high whenever a scan or hand-off is in progress
module mux_scan_ctrl #(
    parameter int DWELL = 2,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       s1,
    output logic       s0,
    input  logic       mux_out,
    output logic [3:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_t           state;
    logic [1:0]       ch;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       shadow;

    // The channel register drives the selects directly, so the selects are
    // flop outputs and need no separate register.
    assign s1 = ch[1];
    assign s0 = ch[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ch     <= 2'd0;
            cnt    <= '0;
            shadow <= 3'd0;
            data   <= 4'd0;
            valid  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SETTLE;
                        ch    <= 2'd0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                SETTLE: begin
                    // The last settle cycle is the one where cnt reaches
                    // DWELL-1. Clearing cnt there keeps it within range.
                    if (cnt == CNT_LAST) begin
                        state <= SAMPLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                SAMPLE: begin
                    if (ch != 2'd3) begin
                        for (int i = 0; i < 3; i++) begin
                            if (ch == 2'(i)) shadow[i] <= mux_out;
                        end
                        ch    <= ch + 2'd1;
                        cnt   <= '0;
                        state <= SETTLE;
                    end else begin
                        // Channel 3 goes straight into the word. The selects
                        // return to 00 while the word waits for acceptance.
                        data  <= {mux_out, shadow};
                        valid <= 1'b1;
                        ch    <= 2'd0;
                        state <= HOLD;
                    end
                end

                HOLD: begin
                    // start is ignored here; a new scan must begin from IDLE.
                    if (ready) begin
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    // Instance A: DWELL=2
    logic       start_a = 1'b0, ready_a = 1'b1, noise_a = 1'b0;
    logic [3:0] chans_a = 4'd0;
    logic       s1_a, s0_a, mux_out_a, valid_a, busy_a;
    logic [3:0] data_a;

    // Instance B: DWELL=1
    logic       start_b = 1'b0, ready_b = 1'b1, noise_b = 1'b0;
    logic [3:0] chans_b = 4'd0;
    logic       s1_b, s0_b, mux_out_b, valid_b, busy_b;
    logic [3:0] data_b;

    int errors = 0;
    int checks = 0;

    logic [3:0] qa[$];
    logic [3:0] qb[$];

    // Behavioural 4:1 mux. noise flips the mux output to emulate a line that
    // is still settling.
    assign mux_out_a = chans_a[{s1_a, s0_a}] ^ noise_a;
    assign mux_out_b = chans_b[{s1_b, s0_b}] ^ noise_b;

    mux_scan_ctrl #(.DWELL(2), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .s1(s1_a), .s0(s0_a),
        .mux_out(mux_out_a), .data(data_a), .valid(valid_a),
        .ready(ready_a), .busy(busy_a)
    );

    mux_scan_ctrl #(.DWELL(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .s1(s1_b), .s0(s0_b),
        .mux_out(mux_out_b), .data(data_b), .valid(valid_b),
        .ready(ready_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitors: a word is transferred at the edge following a
    // cycle with valid && ready, so it is compared at the falling edge of
    // that cycle.
    always @(negedge clk) begin
        if (!rst && valid_a && ready_a) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL word_a: unexpected word %0h, none expected", data_a);
            end else begin
                chk("word_a", {28'd0, data_a}, {28'd0, qa.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && valid_b && ready_b) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL word_b: unexpected word %0h, none expected", data_b);
            end else begin
                chk("word_b", {28'd0, data_b}, {28'd0, qb.pop_front()});
            end
        end
    end

    // One full scan on instance A. After edge e (0..11) the select must be
    // e/3. pulse_e pulses start in the cycle after edge pulse_e; hold_start
    // presents start together with ready in HOLD; stall keeps ready low for
    // that many HOLD cycles.
    task automatic scan_a(input logic [3:0] vals, input logic [3:0] expw,
                          input int pulse_e, input logic hold_start, input int stall);
        chans_a = vals;
        ready_a = (stall == 0);
        qa.push_back(expw);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int e = 0; e < 12; e++) begin
            chk($sformatf("sel_a_e%0d", e), {30'd0, s1_a, s0_a}, e / 3);
            chk($sformatf("nvalid_a_e%0d", e), {31'd0, valid_a}, 32'd0);
            start_a = (e == pulse_e);
            tick();
        end
        start_a = 1'b0;
        chk("valid_a_lat12", {31'd0, valid_a}, 32'd1);
        chk("sel_a_hold", {30'd0, s1_a, s0_a}, 32'd0);
        chk("busy_a_hold", {31'd0, busy_a}, 32'd1);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("valid_a_stall", {31'd0, valid_a}, 32'd1);
            chk("data_a_stall", {28'd0, data_a}, {28'd0, expw});
        end
        ready_a = 1'b1;
        start_a = hold_start;
        tick();
        start_a = 1'b0;
        chk("valid_a_drop", {31'd0, valid_a}, 32'd0);
        chk("busy_a_idle", {31'd0, busy_a}, 32'd0);
        chk("data_a_keep", {28'd0, data_a}, {28'd0, expw});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_sel_a", {30'd0, s1_a, s0_a}, 32'd0);
        chk("rst_data_a", {28'd0, data_a}, 32'd0);
        chk("rst_valid_a", {31'd0, valid_a}, 32'd0);
        chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
        chk("rst_data_b", {28'd0, data_b}, 32'd0);
        chk("rst_busy_b", {31'd0, busy_b}, 32'd0);

        // Basic scan: a..d = 1,0,1,1
        scan_a(4'b1101, 4'b1101, -1, 1'b0, 0);
        tick();

        // Backpressure for 5 cycles
        scan_a(4'b1101, 4'b1101, -1, 1'b0, 5);
        tick();

        // Ignored start in SETTLE of ch1 (after edge 3) and in HOLD
        scan_a(4'b1101, 4'b1101, 3, 1'b1, 0);
        repeat (4) begin
            tick();
            chk("no_restart_busy", {31'd0, busy_a}, 32'd0);
            chk("no_restart_valid", {31'd0, valid_a}, 32'd0);
        end

        // Async reset in SETTLE of ch2 (after edge 6)
        chans_a = 4'b1111;
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (6) tick();
        chk("pre_rst_sel", {30'd0, s1_a, s0_a}, 32'd2);
        rst = 1'b1;
        #1;
        chk("arst_sel", {30'd0, s1_a, s0_a}, 32'd0);
        chk("arst_valid", {31'd0, valid_a}, 32'd0);
        chk("arst_busy", {31'd0, busy_a}, 32'd0);
        chk("arst_data", {28'd0, data_a}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        scan_a(4'b0110, 4'b0110, -1, 1'b0, 0);

        // DWELL=1 on instance B: a..d = 0,0,0,1, noise during SETTLE
        chans_b = 4'b1000;
        ready_b = 1'b1;
        qb.push_back(4'b1000);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int e = 0; e < 8; e++) begin
            chk($sformatf("sel_b_e%0d", e), {30'd0, s1_b, s0_b}, e / 2);
            chk($sformatf("nvalid_b_e%0d", e), {31'd0, valid_b}, 32'd0);
            noise_b = ((e % 2) == 0);
            tick();
        end
        noise_b = 1'b0;
        chk("valid_b_lat8", {31'd0, valid_b}, 32'd1);
        chk("data_b_word", {28'd0, data_b}, 32'h8);
        tick();
        chk("valid_b_drop", {31'd0, valid_b}, 32'd0);
        chk("busy_b_idle", {31'd0, busy_b}, 32'd0);

        repeat (3) tick();
        chk("qa_drained", qa.size(), 32'd0);
        chk("qb_drained", qb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
